// File: rtl/replay_tx.sv
// replay_tx: transmit side of the replay buffer path.
// Pops words from an upstream FIFO, tags each with a sequence number and sends
// it on a valid/ready link. Every sent word stays in a small replay window until
// the far end acknowledges it; a NAK rewinds transmission to the oldest
// unacknowledged word.
module replay_tx #(
  parameter int DW    = 8,
  parameter int WIN   = 4,
  parameter int SEQ_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  input  logic [DW-1:0]    fifo_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [DW-1:0]    tx_data,
  output logic [SEQ_W-1:0] tx_seq,
  input  logic             ack_valid,
  input  logic [SEQ_W-1:0] ack_seq,
  input  logic             nak_valid,
  output logic             win_full,
  output logic             win_empty,
  output logic             replaying,
  output logic             ack_err
);

  localparam int AW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [SEQ_W-1:0] ONE     = SEQ_W'(1);
  localparam logic [SEQ_W-1:0] WIN_CNT = SEQ_W'(WIN);

  typedef enum logic { F_IDLE, F_WAIT } fetch_t;
  typedef enum logic { RUN, REPLAY } tx_state_t;

  // base = oldest unacked, send = next to send, next = next free slot
  logic [SEQ_W-1:0] base;
  logic [SEQ_W-1:0] send;
  logic [SEQ_W-1:0] next;
  logic [SEQ_W-1:0] replay_end;
  logic [DW-1:0]    mem [0:WIN-1];
  fetch_t           fstate;
  tx_state_t        tstate;
  logic             nak_pend;
  logic             ack_err_q;

  logic [SEQ_W-1:0] count;
  logic [SEQ_W-1:0] ack_off;
  logic [SEQ_W-1:0] sent_cnt;
  logic [SEQ_W-1:0] base_nx;
  logic [SEQ_W-1:0] send_hs;
  logic             handshake;
  logic             ack_ok;
  logic             nak_apply;

  // Window occupancy, link outputs and the pop decision, all derived from the pointers.
  always_comb begin
    count     = next - base;
    win_full  = (count == WIN_CNT);
    win_empty = (count == '0);
    tx_valid  = (send != next);
    tx_data   = mem[send[AW-1:0]];
    tx_seq    = send;
    replaying = (tstate == REPLAY);
    ack_err   = ack_err_q;
    fifo_rd   = !reset && (fstate == F_IDLE) && !fifo_empty && (count < WIN_CNT);
  end

  // Event decode: handshake, ACK range test (offsets from base avoid wrap issues)
  // and whether a NAK may rewind this cycle without disturbing a stalled beat.
  always_comb begin
    handshake = tx_valid && tx_ready;
    ack_off   = ack_seq - base;
    sent_cnt  = send - base;
    ack_ok    = ack_valid && (ack_off < sent_cnt);
    base_nx   = ack_ok ? (ack_seq + ONE) : base;
    send_hs   = handshake ? (send + ONE) : send;
    nak_apply = (nak_valid || nak_pend) && !(tx_valid && !tx_ready);
  end

  // Fetch FSM, replay window storage, pointer updates and the tx FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      base       <= '0;
      send       <= '0;
      next       <= '0;
      replay_end <= '0;
      fstate     <= F_IDLE;
      tstate     <= RUN;
      nak_pend   <= 1'b0;
      ack_err_q  <= 1'b0;
      for (int i = 0; i < WIN; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (fstate)
        F_IDLE: begin
          if (fifo_rd) begin
            fstate <= F_WAIT;
          end
        end
        F_WAIT: begin
          mem[next[AW-1:0]] <= fifo_data;
          next              <= next + ONE;
          fstate            <= F_IDLE;
        end
        default: fstate <= F_IDLE;
      endcase

      base      <= base_nx;
      ack_err_q <= ack_valid && !ack_ok;

      if (nak_apply) begin
        nak_pend <= 1'b0;
        send     <= base_nx;
        if (tstate == RUN) begin
          if (base_nx != send_hs) begin
            tstate     <= REPLAY;
            replay_end <= send_hs;
          end
        end else if (base_nx == replay_end) begin
          tstate <= RUN;
        end
      end else begin
        nak_pend <= nak_pend || nak_valid;
        send     <= send_hs;
        if ((tstate == REPLAY) && (send_hs == replay_end)) begin
          tstate <= RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_replay_tx.sv
// tb_replay_tx: directed self-checking bench for replay_tx.
module tb_replay_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo_empty;
  logic       fifo_rd;
  logic [7:0] fifo_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic [2:0] tx_seq;
  logic       ack_valid;
  logic [2:0] ack_seq;
  logic       nak_valid;
  logic       win_full;
  logic       win_empty;
  logic       replaying;
  logic       ack_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] fmem [0:63];
  int wr_idx = 0;
  int rd_idx = 0;

  replay_tx #(.DW(8), .WIN(4), .SEQ_W(3)) dut (
    .clk(clk), .reset(reset),
    .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .fifo_data(fifo_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_seq(tx_seq),
    .ack_valid(ack_valid), .ack_seq(ack_seq), .nak_valid(nak_valid),
    .win_full(win_full), .win_empty(win_empty), .replaying(replaying), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rd_idx == wr_idx);

  // Upstream FIFO model: data appears the cycle after the pop strobe.
  always @(posedge clk) begin
    if (fifo_rd && (rd_idx != wr_idx)) begin
      fifo_data <= fmem[rd_idx];
      rd_idx    <= rd_idx + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    fmem[wr_idx] = d;
    wr_idx = wr_idx + 1;
    #1;
  endtask

  task automatic applyStimulus(input logic rdy, input logic av, input logic [2:0] as,
                               input logic nv);
    tx_ready  = rdy;
    ack_valid = av;
    ack_seq   = as;
    nak_valid = nv;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyReset(input logic rdy);
    reset = 1'b1;
    applyStimulus(rdy, 1'b0, 3'd0, 1'b0);
    tick();
    tick();
  endtask

  initial begin
    int k;
    int cyc;
    logic       prev_hs;
    logic [2:0] prev_seq;

    fifo_data = '0;
    applyReset(1'b1);
    checkOutput("rst_tx_valid", tx_valid, 0);
    checkOutput("rst_fifo_rd", fifo_rd, 0);
    checkOutput("rst_win_empty", win_empty, 1);
    checkOutput("rst_win_full", win_full, 0);
    checkOutput("rst_replaying", replaying, 0);
    checkOutput("rst_ack_err", ack_err, 0);
    checkOutput("rst_tx_seq", tx_seq, 0);

    // Basic streaming of three words
    $display("[TB] streaming three words");
    push(8'hA0); push(8'hA1); push(8'hA2);
    reset = 1'b0; #1;
    checkOutput("t1_rd_c0", fifo_rd, 1);
    tick();
    checkOutput("t1_rd_c1", fifo_rd, 0);
    checkOutput("t1_valid_c1", tx_valid, 0);
    tick();
    checkOutput("t1_rd_c2", fifo_rd, 1);
    checkOutput("t1_seq0", tx_seq, 0);
    checkOutput("t1_data0", tx_data, 8'hA0);
    checkOutput("t1_valid0", tx_valid, 1);
    tick();
    checkOutput("t1_rd_c3", fifo_rd, 0);
    tick();
    checkOutput("t1_rd_c4", fifo_rd, 1);
    checkOutput("t1_seq1", tx_seq, 1);
    checkOutput("t1_data1", tx_data, 8'hA1);
    tick(); tick();
    checkOutput("t1_seq2", tx_seq, 2);
    checkOutput("t1_data2", tx_data, 8'hA2);
    checkOutput("t1_rd_c6", fifo_rd, 0);
    tick();
    checkOutput("t1_valid_c7", tx_valid, 0);
    applyStimulus(1'b1, 1'b1, 3'd2, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
    checkOutput("t1_empty_after_ack", win_empty, 1);

    // Full window stalls the fetch
    $display("[TB] full window");
    applyReset(1'b1);
    push(8'hB0); push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
    reset = 1'b0; #1;
    for (int i = 0; i < 8; i++) tick();
    checkOutput("t2_full", win_full, 1);
    checkOutput("t2_rd_full", fifo_rd, 0);
    checkOutput("t2_seq3", tx_seq, 3);
    checkOutput("t2_data3", tx_data, 8'hB3);
    tick();
    checkOutput("t2_valid_idle", tx_valid, 0);
    checkOutput("t2_rd_still0", fifo_rd, 0);
    applyStimulus(1'b1, 1'b1, 3'd1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
    checkOutput("t2_rd_resume", fifo_rd, 1);
    checkOutput("t2_not_full", win_full, 0);
    tick(); tick();
    checkOutput("t2_seq4", tx_seq, 4);
    checkOutput("t2_data4", tx_data, 8'hB4);

    // ACK then NAK replays the unacked words
    $display("[TB] ack then nak replay");
    applyReset(1'b1);
    push(8'hC0); push(8'hC1); push(8'hC2); push(8'hC3);
    reset = 1'b0; #1;
    for (int i = 0; i < 9; i++) tick();
    applyStimulus(1'b1, 1'b1, 3'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b1);
    checkOutput("t3_not_yet_replay", replaying, 0);
    tick();
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
    checkOutput("t3_replaying", replaying, 1);
    checkOutput("t3_seq1", tx_seq, 1);
    checkOutput("t3_data1", tx_data, 8'hC1);
    tick();
    checkOutput("t3_seq2", tx_seq, 2);
    checkOutput("t3_data2", tx_data, 8'hC2);
    tick();
    checkOutput("t3_seq3", tx_seq, 3);
    checkOutput("t3_data3", tx_data, 8'hC3);
    checkOutput("t3_replay_last", replaying, 1);
    tick();
    checkOutput("t3_run", replaying, 0);
    checkOutput("t3_idle", tx_valid, 0);

    // NAK during a stalled beat
    $display("[TB] nak while stalled");
    applyReset(1'b0);
    push(8'hD0); push(8'hD1);
    reset = 1'b0; #1;
    for (int i = 0; i < 4; i++) tick();
    checkOutput("t4_valid", tx_valid, 1);
    checkOutput("t4_seq0", tx_seq, 0);
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 3'd0, 1'b0);
    checkOutput("t4_hold_seq", tx_seq, 0);
    checkOutput("t4_hold_data", tx_data, 8'hD0);
    checkOutput("t4_no_replay", replaying, 0);
    tick();
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
    tick();
    checkOutput("t4_replaying", replaying, 1);
    checkOutput("t4_reseq0", tx_seq, 0);
    checkOutput("t4_redata0", tx_data, 8'hD0);
    tick();
    checkOutput("t4_run", replaying, 0);
    checkOutput("t4_seq1", tx_seq, 1);
    checkOutput("t4_data1", tx_data, 8'hD1);
    tick();
    checkOutput("t4_idle", tx_valid, 0);

    // Out-of-range ACKs
    $display("[TB] ack range errors");
    applyReset(1'b1);
    push(8'hE0); push(8'hE1);
    reset = 1'b0; #1;
    for (int i = 0; i < 5; i++) tick();
    applyStimulus(1'b1, 1'b1, 3'd5, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
    checkOutput("t5_err_pulse", ack_err, 1);
    checkOutput("t5_base_kept", win_empty, 0);
    tick();
    checkOutput("t5_err_clear", ack_err, 0);
    applyStimulus(1'b1, 1'b1, 3'd1, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 3'd1, 1'b0);
    checkOutput("t5_good_ack", ack_err, 0);
    checkOutput("t5_empty", win_empty, 1);
    tick();
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
    checkOutput("t5_dup_ack_err", ack_err, 1);

    // Twenty words with immediate ACKs, sequence wraps
    $display("[TB] twenty words with wrap");
    applyReset(1'b1);
    for (int i = 0; i < 20; i++) push(8'h10 + 8'(i));
    reset = 1'b0; #1;
    k = 0;
    cyc = 0;
    prev_hs = 1'b0;
    prev_seq = '0;
    while ((k < 20) && (cyc < 200)) begin
      tick();
      cyc++;
      applyStimulus(1'b1, prev_hs, prev_seq, 1'b0);
      prev_hs = 1'b0;
      if (tx_valid) begin
        checkOutput("t6_seq", tx_seq, k % 8);
        checkOutput("t6_data", tx_data, 32'h10 + k);
        prev_hs = 1'b1;
        prev_seq = 3'(k);
        k++;
      end
    end
    checkOutput("t6_count", k, 20);
    tick();
    applyStimulus(1'b1, 1'b1, prev_seq, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 3'd0, 1'b0);
    checkOutput("t6_drained", win_empty, 1);
    checkOutput("t6_no_err", ack_err, 0);

    // Reset during a pop
    $display("[TB] reset during pop");
    push(8'hF0);
    checkOutput("t7_rd", fifo_rd, 1);
    tick();
    reset = 1'b1; #1;
    tick();
    checkOutput("t7_rd0", fifo_rd, 0);
    checkOutput("t7_valid0", tx_valid, 0);
    checkOutput("t7_empty", win_empty, 1);
    checkOutput("t7_data0", tx_data, 0);
    reset = 1'b0; #1;
    tick();
    checkOutput("t7_dropped", tx_valid, 0);
    checkOutput("t7_next0", win_empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
